// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : issue_sched
// Description : Function-unit scheduler for the issue stage. Tracks LSU
//               credits and iterative-divider occupancy, publishes a per-FU
//               ready mask to the issue queue and grants candidate slots in
//               order, subject to per-cycle FU port limits.
// Ports       : clk, rst            clock, synchronous active-high reset
//               redir               pipeline redirect; releases all FU state
//               slot_vld[IWD]       candidate slot holds a valid op
//               slot_fu[IWD][5]     FU mask per slot (ALU,LSU,MUL,DIV,BRU)
//               lsu_ret[CW]         LSU credits returned this cycle
//               fu_ready[5]         per-FU ready mask (registered state only)
//               issue[IWD]          per-slot grant (combinational)
//               div_busy            divider occupied
//               stall_cnt[32]       cycles with slot 0 valid but not granted
// Revision    : 1.0 - initial release
// ============================================================================
module issue_sched #(
    parameter int IWD    = 4,
    parameter int NALU   = 2,
    parameter int LSUCR  = 8,
    parameter int DIVLAT = 16,
    localparam int c_CW  = $clog2(LSUCR + 1),
    localparam int c_DW  = $clog2(DIVLAT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redir,
    input  logic [IWD-1:0]      slot_vld,
    input  logic [IWD-1:0][4:0] slot_fu,
    input  logic [c_CW-1:0]     lsu_ret,
    output logic [4:0]          fu_ready,
    output logic [IWD-1:0]      issue,
    output logic                div_busy,
    output logic [31:0]         stall_cnt
);

    localparam logic [c_CW-1:0] c_CRED_RST = c_CW'(LSUCR);
    localparam logic [c_CW:0]   c_CRED_MAX = (c_CW + 1)'(LSUCR);
    localparam logic [c_DW-1:0] c_DIV_LOAD = c_DW'(DIVLAT - 1);

    logic [c_CW-1:0] r_cred;
    logic [c_DW-1:0] r_dcnt;
    logic [31:0]     r_stall_cnt;

    logic [IWD-1:0]  w_issue;
    logic            w_lsu_g;
    logic            w_div_g;
    logic            w_mul_g;
    logic            w_bru_g;
    int              w_alu_n;
    logic            w_blocked;
    logic            w_ok;
    logic [4:0]      w_sel;
    logic [c_CW:0]   w_cred_sum;

    // ------------------------------------------------------------------------
    // In-order prefix grant. Each slot targets the FU of the lowest set bit
    // of its mask; the first valid slot that cannot be served blocks the
    // rest, while invalid slots are transparent.
    // ------------------------------------------------------------------------
    always_comb begin
        w_issue   = '0;
        w_lsu_g   = 1'b0;
        w_div_g   = 1'b0;
        w_mul_g   = 1'b0;
        w_bru_g   = 1'b0;
        w_alu_n   = 0;
        w_blocked = 1'b0;
        w_ok      = 1'b0;
        w_sel     = '0;
        for (int i = 0; i < IWD; i++) begin
            // Two's-complement trick isolates the lowest set bit (0 if none).
            w_sel = slot_fu[i] & (~slot_fu[i] + 5'd1);
            w_ok  = 1'b0;
            if (slot_vld[i] && !w_blocked) begin
                if (w_sel[0])      w_ok = (w_alu_n < NALU);
                else if (w_sel[1]) w_ok = !w_lsu_g && (r_cred != '0);
                else if (w_sel[2]) w_ok = !w_mul_g;
                else if (w_sel[3]) w_ok = !w_div_g && (r_dcnt == '0);
                else if (w_sel[4]) w_ok = !w_bru_g;
                if (w_ok) begin
                    w_issue[i] = 1'b1;
                    if (w_sel[0]) w_alu_n = w_alu_n + 1;
                    if (w_sel[1]) w_lsu_g = 1'b1;
                    if (w_sel[2]) w_mul_g = 1'b1;
                    if (w_sel[3]) w_div_g = 1'b1;
                    if (w_sel[4]) w_bru_g = 1'b1;
                end else begin
                    w_blocked = 1'b1;
                end
            end
        end
        if (rst) begin
            w_issue = '0;
        end
    end

    // One extra bit so that the sum can exceed LSUCR before saturation.
    // Underflow is impossible: an LSU grant requires r_cred != 0.
    always_comb begin
        w_cred_sum = {1'b0, r_cred} - {{c_CW{1'b0}}, w_lsu_g} + {1'b0, lsu_ret};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cred      <= c_CRED_RST;
            r_dcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (slot_vld[0] && !w_issue[0]) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redir) begin
                // Flushed ops release every resource; same-cycle grants and
                // returns are discarded.
                r_cred <= c_CRED_RST;
                r_dcnt <= '0;
            end else begin
                r_cred <= (w_cred_sum > c_CRED_MAX) ? c_CRED_RST : w_cred_sum[c_CW-1:0];
                if (w_div_g) begin
                    r_dcnt <= c_DIV_LOAD;
                end else if (r_dcnt != '0) begin
                    r_dcnt <= r_dcnt - 1'b1;
                end
            end
        end
    end

    // Ready mask reflects registered state only; no path from slot inputs.
    always_comb begin
        if (rst) begin
            fu_ready = '0;
        end else begin
            fu_ready = {1'b1, (r_dcnt == '0), 1'b1, (r_cred != '0), 1'b1};
        end
    end

    assign issue     = w_issue;
    assign div_busy  = (r_dcnt != '0);
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
